// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_pkg : shared state encoding and default width for iter_div      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package div_pkg;

  localparam int DIV_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/iter_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iter_div : restoring radix-2 signed/unsigned divider, AXI-S ports   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module iter_div
  import div_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_signed,
  input  logic [DW-1:0]   s_axis_dividend_tdata,
  input  logic            s_axis_dividend_tvalid,
  output logic            s_axis_dividend_tready,
  input  logic [DW-1:0]   s_axis_divisor_tdata,
  input  logic            s_axis_divisor_tvalid,
  output logic            s_axis_divisor_tready,
  output logic [2*DW-1:0] m_axis_dout_tdata,
  output logic            m_axis_dout_tvalid,
  input  logic            m_axis_dout_tready
);

  localparam logic [DW-1:0] C_LAST = DW'(DW);

  div_state_t      state_q, state_d;
  logic [DW-1:0]   cnt_q;
  logic [DW-1:0]   rem_q;
  logic [DW-1:0]   quo_q;
  logic [DW-1:0]   dvs_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [2*DW-1:0] res_q;

  logic            w_accept;
  logic            w_last;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic            w_dvs_zero;
  logic [DW-1:0]   w_dvd_mag;
  logic [DW-1:0]   w_dvs_mag;
  logic [DW:0]     w_trial;
  logic [DW:0]     w_diff;
  logic            w_qbit;

  assign w_accept   = (state_q == ST_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign w_last     = (cnt_q == C_LAST);

  // A zero divisor keeps the raw dividend and no sign fix-up, so the plain
  // restoring loop naturally yields all-ones quotient and remainder = dividend.
  assign w_dvs_zero = (s_axis_divisor_tdata == '0);
  assign w_dvd_neg  = div_signed && s_axis_dividend_tdata[DW-1] && !w_dvs_zero;
  assign w_dvs_neg  = div_signed && s_axis_divisor_tdata[DW-1];
  assign w_dvd_mag  = w_dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign w_dvs_mag  = w_dvs_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

  // Bit DW of the difference is the borrow: set means the trial subtract fails.
  assign w_trial    = {rem_q, quo_q[DW-1]};
  assign w_diff     = w_trial - {1'b0, dvs_q};
  assign w_qbit     = ~w_diff[DW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = ST_BUSY;
      ST_BUSY: if (w_last) state_d = ST_DONE;
      ST_DONE: if (m_axis_dout_tready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (w_accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= w_dvd_mag;
      dvs_q     <= w_dvs_mag;
      neg_quo_q <= (w_dvd_neg ^ w_dvs_neg) && !w_dvs_zero;
      neg_rem_q <= w_dvd_neg;
    end else if (state_q == ST_BUSY) begin
      if (w_last) begin
        res_q <= {(neg_quo_q ? -quo_q : quo_q), (neg_rem_q ? -rem_q : rem_q)};
      end else begin
        rem_q <= w_qbit ? w_diff[DW-1:0] : w_trial[DW-1:0];
        quo_q <= {quo_q[DW-2:0], w_qbit};
        cnt_q <= cnt_q + DW'(1);
      end
    end
  end

  assign s_axis_dividend_tready = (state_q == ST_IDLE);
  assign s_axis_divisor_tready  = (state_q == ST_IDLE);
  assign m_axis_dout_tvalid     = (state_q == ST_DONE);
  assign m_axis_dout_tdata      = res_q;

endmodule
`default_nettype wire

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port div_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled at operand acceptance.
REQ-005 SHALL have port s_axis_dividend_tdata  input  DW  dividend.
REQ-006 SHALL have port s_axis_dividend_tvalid  input  1  dividend offered.
REQ-007 SHALL have port s_axis_dividend_tready  output  1  dividend can be taken.
REQ-008 SHALL have port s_axis_divisor_tdata  input  DW  divisor.
REQ-009 SHALL have port s_axis_divisor_tvalid  input  1  divisor offered.
REQ-010 SHALL have port s_axis_divisor_tready  output  1  divisor can be taken.
REQ-011 SHALL have port m_axis_dout_tdata  output  2*DW  {quotient, remainder}, quotient in upper half.
REQ-012 SHALL have port m_axis_dout_tvalid  output  1  result valid.
REQ-013 SHALL have port m_axis_dout_tready  input  1  consumer accepts result.

Function
REQ-014 SHALL implement three states: IDLE, BUSY, DONE.
REQ-015 SHALL drive both s_axis tready high only in IDLE, low in BUSY and DONE.
REQ-016 SHALL accept operands only in IDLE, in a cycle where dividend tvalid and divisor tvalid are both high; a lone tvalid is not accepted and leaves state unchanged.
REQ-017 SHALL, on acceptance, latch operands and div_signed, and go IDLE -> BUSY.
REQ-018 SHALL perform restoring radix-2 division on magnitudes, one quotient bit per cycle, DW cycles in BUSY, with a DW-bit iteration counter.
REQ-019 SHALL go BUSY -> DONE after the DW-th iteration; m_axis_dout_tvalid rises exactly DW+1 cycles after the acceptance edge.
REQ-020 SHALL, in signed mode, take magnitudes of both operands, negate the quotient when the operand signs differ, and give the remainder the dividend's sign.
REQ-021 SHALL yield quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF (DW=32), with no exception.
REQ-022 SHALL, for divisor 0 (either mode), yield quotient all-ones and remainder equal to the raw dividend, with the same DW+1 latency.
REQ-023 SHALL hold m_axis_dout_tvalid and tdata stable in DONE until m_axis_dout_tready is high, then go DONE -> IDLE on that edge.
REQ-024 SHALL keep m_axis_dout_tvalid low in IDLE and BUSY; tdata is don't-care then.
REQ-025 SHALL ignore input tvalid/tdata changes while in BUSY or DONE.
REQ-026 SHALL allow a new acceptance no earlier than the cycle after the result handshake.

Reset
REQ-027 SHALL, when reset is high on a clock edge, enter IDLE, clear the counter, and drive m_axis_dout_tvalid = 0 and both s_axis tready = 1 from the next cycle.
REQ-028 SHALL let reset override any state, including mid-BUSY and DONE, discarding the in-flight result.
REQ-029 SHALL ignore tvalid in any cycle where reset is high.

Structure
REQ-030 SHALL take the state encoding (IDLE/BUSY/DONE) and the default DW from a shared package div_pkg.
REQ-031 SHALL be a single module with no sub-module; magnitude/negation logic stays inline.

Verification
REQ-032 SHALL cover signed 7 / 2 -> quotient 0x00000003, remainder 0x00000001, tvalid exactly 33 cycles after acceptance.
REQ-033 SHALL cover signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFFF / 2 -> quotient 0x7FFFFFFF, remainder 1.
REQ-034 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; divisor 0 with dividend 5 -> quotient 0xFFFFFFFF, remainder 5.
REQ-035 SHALL cover m_axis_dout_tready held low 10 cycles in DONE -> tvalid and tdata stable throughout; IDLE one cycle after tready rises.
REQ-036 SHALL cover only dividend tvalid high for 5 cycles -> no acceptance; then both tvalid high -> acceptance that cycle.
REQ-037 SHALL cover reset pulsed at BUSY iteration 10 -> tvalid never asserts for that operation; a new 9 / 3 gives quotient 3, remainder 0.
